// File: rtl/mv_pattern_defs_pkg.sv
// Shared definitions for the test-pattern controller and the pattern mux:
// mode index width, default number of patterns, FSM state encodings and
// the wrap-around mode step helper.
package mv_pattern_defs;

    localparam int MODE_W        = 4;
    localparam int NUM_MODES_DEF = 7;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    // One step up or down within 0..last, wrapping at both ends.
    function automatic logic [MODE_W-1:0] mode_step(
        input logic [MODE_W-1:0] cur,
        input logic              up,
        input logic [MODE_W-1:0] last
    );
        logic [MODE_W-1:0] nxt;
        if (up) begin
            nxt = (cur >= last) ? '0 : cur + 4'd1;
        end else begin
            nxt = (cur == '0) ? last : cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mv_pattern_ctrl_key_debounce.sv
// mv_key_debounce: 2-flop synchronizer, stable-level debounce and a
// one-cycle press pulse for an active-low pushbutton. The accepted level
// starts at released (1); a new level is taken once DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with the accepted level.
module mv_key_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic [19:0] cnt_q, cnt_d;
    logic        press_q, press_d;

    // Down-counter reloads while the sample matches; terminal count accepts.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = DEBOUNCE_CYCLES;
        end else if (cnt_q <= 20'd1) begin
            level_d = sync2_q;
            cnt_d   = DEBOUNCE_CYCLES;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q - 20'd1;
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= DEBOUNCE_CYCLES;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mv_pattern_ctrl.sv
// mv_pattern_ctrl: turns next/prev pushbuttons into a pattern mode index,
// committing each step only at an active vsync edge so no frame mixes
// patterns. Optional auto-cycle stepping is compiled in with the macro
// MV_PATTERN_AUTO_CYCLE_EN; without it auto_en is ignored.
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  ST_IDLE    | no request; key (or auto) events are accepted
//  ST_PENDING | target holds the next mode; commits on the next frame edge
module mv_pattern_ctrl
    import mv_pattern_defs::*;
#(
    parameter int          NUM_MODES       = NUM_MODES_DEF,
    parameter logic [3:0]  INIT_MODE       = 4'd0,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [15:0] AUTO_FRAMES     = 16'd300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next_n,
    input  logic       key_prev_n,
    input  logic       auto_en,
    input  logic       positive_vsync,
    input  logic       vs_in,
    output logic [3:0] mode,
    output logic       mode_update,
    output logic       pending
);

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    logic              press_next, press_prev;
    logic              ev_next_key, ev_prev_key, ev_next;
    logic              vs_act, vs_act_d1_q, fe;
    logic              state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [MODE_W-1:0] target_q, target_d;
    logic              update_q, update_d;

    mv_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_next_n),
        .press_o (press_next)
    );

    mv_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_prev_n),
        .press_o (press_prev)
    );

    // Simultaneous next+prev cancel each other.
    assign ev_next_key = press_next & ~press_prev;
    assign ev_prev_key = press_prev & ~press_next;

    assign vs_act = positive_vsync ? vs_in : ~vs_in;
    assign fe     = vs_act & ~vs_act_d1_q;

`ifdef MV_PATTERN_AUTO_CYCLE_EN
    logic [15:0] frame_q, frame_d;
    logic        key_any;
    logic        auto_req;

    assign key_any = press_next | press_prev;

    // Frame counter: counts idle frame edges, requests a step when it reaches AUTO_FRAMES-1.
    always_comb begin
        frame_d  = frame_q;
        auto_req = 1'b0;
        if (!auto_en || key_any) begin
            frame_d = '0;
        end else if (fe && (state_q == ST_IDLE)) begin
            if ((frame_q + 16'd1) >= (AUTO_FRAMES - 16'd1)) begin
                frame_d  = '0;
                auto_req = 1'b1;
            end else begin
                frame_d = frame_q + 16'd1;
            end
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    // A key event in the same cycle wins over the auto request.
    assign ev_next = ev_next_key | (auto_req & ~key_any);
`else
    logic                  unused_auto_en;
    localparam logic [15:0] UNUSED_AUTO_FRAMES = AUTO_FRAMES;

    assign unused_auto_en = auto_en ^ UNUSED_AUTO_FRAMES[0];
    assign ev_next        = ev_next_key;
`endif

    // Request/commit FSM: one step latched per frame, applied at the frame edge.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        update_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ev_next) begin
                target_d = mode_step(mode_q, 1'b1, LAST_MODE);
                state_d  = ST_PENDING;
            end else if (ev_prev_key) begin
                target_d = mode_step(mode_q, 1'b0, LAST_MODE);
                state_d  = ST_PENDING;
            end
        end else begin
            if (fe) begin
                mode_d   = target_q;
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

    // FSM, mode and frame-edge history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= INIT_MODE;
            target_q    <= INIT_MODE;
            update_q    <= 1'b0;
            vs_act_d1_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            update_q    <= update_d;
            vs_act_d1_q <= vs_act;
        end
    end

    assign mode        = mode_q;
    assign mode_update = update_q;
    assign pending     = (state_q == ST_PENDING);

endmodule

// File: tb/tb_mv_pattern_ctrl.sv
// Directed bench for mv_pattern_ctrl with short debounce and auto-frame
// settings; auto-cycle steps only run when MV_PATTERN_AUTO_CYCLE_EN is set.
module tb_mv_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_next_n, key_prev_n;
    logic       auto_en, positive_vsync, vs_in;
    logic [3:0] mode;
    logic       mode_update, pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mv_pattern_ctrl #(
        .NUM_MODES       (7),
        .INIT_MODE       (4'd0),
        .DEBOUNCE_CYCLES (20'd4),
        .AUTO_FRAMES     (16'd3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_next_n     (key_next_n),
        .key_prev_n     (key_prev_n),
        .auto_en        (auto_en),
        .positive_vsync (positive_vsync),
        .vs_in          (vs_in),
        .mode           (mode),
        .mode_update    (mode_update),
        .pending        (pending)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse();
        vs_in = positive_vsync;
        tick();
        vs_in = ~positive_vsync;
        tick();
    endtask

    task automatic press_next();
        key_next_n = 1'b0;
        tick(10);
        key_next_n = 1'b1;
        tick(10);
    endtask

    task automatic press_prev();
        key_prev_n = 1'b0;
        tick(10);
        key_prev_n = 1'b1;
        tick(10);
    endtask

    initial begin
        rst = 1'b1; key_next_n = 1'b1; key_prev_n = 1'b1;
        auto_en = 1'b0; positive_vsync = 1'b1; vs_in = 1'b0;
        tick(2);
        chk("rst_mode", mode, 0);
        chk("rst_update", mode_update, 0);
        chk("rst_pending", pending, 0);
        rst = 1'b0;
        tick();
        repeat (3) vs_pulse();
        chk("rst_vs_mode", mode, 0);
        chk("rst_vs_pending", pending, 0);

        // Bounce: short glitches rejected, long hold gives one event.
        repeat (3) begin
            key_next_n = 1'b0; tick(2);
            key_next_n = 1'b1; tick(2);
        end
        tick(8);
        chk("bounce_no_pend", pending, 0);
        key_next_n = 1'b0;
        tick(10);
        chk("bounce_pend", pending, 1);
        key_next_n = 1'b1;
        tick(10);
        chk("bounce_hold_mode", mode, 0);
        vs_in = 1'b1;
        tick();
        chk("bounce_commit", mode, 1);
        chk("bounce_upd_hi", mode_update, 1);
        vs_in = 1'b0;
        tick();
        chk("bounce_upd_lo", mode_update, 0);
        chk("bounce_pend_clr", pending, 0);
        vs_pulse();
        chk("bounce_single", mode, 1);

        // Wrap both ways.
        repeat (5) begin
            press_next();
            vs_pulse();
        end
        chk("walk_to_6", mode, 6);
        press_next(); vs_pulse();
        chk("wrap_up", mode, 0);
        press_prev(); vs_pulse();
        chk("wrap_down", mode, 6);

        // Active-low vsync commits on the falling edge only.
        positive_vsync = 1'b0; vs_in = 1'b1;
        tick(3);
        press_prev();
        chk("neg_pend", pending, 1);
        tick(3);
        chk("neg_hold", mode, 6);
        vs_in = 1'b0;
        tick();
        chk("neg_commit", mode, 5);
        chk("neg_upd", mode_update, 1);
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
        positive_vsync = 1'b1;
        tick(2);
        chk("neg_restore", mode, 5);

        // Press during PENDING is dropped.
        rst = 1'b1; tick(2); rst = 1'b0; tick();
        press_next(); vs_pulse();
        press_next(); vs_pulse();
        chk("drop_setup", mode, 2);
        press_next();
        press_next();
        vs_pulse();
        chk("drop_one_step", mode, 3);
        vs_pulse();
        chk("drop_no_second", mode, 3);
        chk("drop_pend_clr", pending, 0);

        // Next and prev together cancel.
        key_next_n = 1'b0; key_prev_n = 1'b0;
        tick(10);
        chk("both_no_pend", pending, 0);
        key_next_n = 1'b1; key_prev_n = 1'b1;
        tick(10);
        vs_pulse();
        chk("both_mode", mode, 3);

        // Event coincident with a frame edge waits for the following edge.
        // Press pulse is present after 2 sync + 4 debounce samples.
        key_next_n = 1'b0;
        tick(6);
        chk("coinc_pre", pending, 0);
        vs_in = 1'b1;
        tick();
        chk("coinc_pend", pending, 1);
        chk("coinc_no_commit", mode, 3);
        vs_in = 1'b0;
        tick(3);
        key_next_n = 1'b1;
        tick(10);
        chk("coinc_hold", mode, 3);
        vs_pulse();
        chk("coinc_commit", mode, 4);

        // Reset while pending discards the request.
        press_next();
        chk("midrst_pend", pending, 1);
        rst = 1'b1; tick(2); rst = 1'b0;
        chk("midrst_pend_clr", pending, 0);
        chk("midrst_mode", mode, 0);
        tick();
        vs_pulse(); vs_pulse();
        chk("midrst_no_commit", mode, 0);

`ifdef MV_PATTERN_AUTO_CYCLE_EN
        // Auto-cycle: one step every 3 frames; a key press clears the count.
        auto_en = 1'b1;
        tick();
        vs_pulse(); vs_pulse();
        chk("auto_pend1", pending, 1);
        chk("auto_hold1", mode, 0);
        vs_pulse();
        chk("auto_step1", mode, 1);
        vs_pulse(); vs_pulse();
        chk("auto_pend2", pending, 1);
        vs_pulse();
        chk("auto_step2", mode, 2);
        vs_pulse();
        press_next();
        vs_pulse();
        chk("auto_key_step", mode, 3);
        vs_pulse();
        chk("auto_cnt_cleared", pending, 0);
        vs_pulse();
        chk("auto_pend3", pending, 1);
        vs_pulse();
        chk("auto_step3", mode, 4);
        auto_en = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
